// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register feeding the EX-stage ALU.
//   Captures the decoded instruction bundle every clock, honouring flush
//   (bubble) over stall (hold, refreshed by MEM/WB write-back) over load.
//   Resolves EX/MEM and MEM/WB forwarding on the registered rs/rt values,
//   selects ALU operands, and flags load-use hazards for the front end.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   id_*                           decoded instruction from ID
//   stall, flush                   pipeline control from hazard logic
//   mem_wr_en/idx, mem_fwd_data    EX/MEM forwarding source
//   wb_wr_en/idx,  wb_fwd_data     MEM/WB forwarding source
//   ex_valid, ex_alu_a/b/op        ALU inputs for the EX stage
//   ex_store_data                  forwarded rt for stores
//   ex_wr_en/idx, ex_mem_rd/wr     registered destination/memory control
//   load_use_hazard                stall request to PC/IF-ID
module id_ex_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IDX_W  = 5,
  parameter int unsigned OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [IDX_W-1:0]  id_rs_idx,
  input  logic [IDX_W-1:0]  id_rt_idx,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [4:0]        id_shamt,
  input  logic [OP_W-1:0]   id_alu_op,
  input  logic              id_a_sel,
  input  logic              id_b_sel,
  input  logic              id_wr_en,
  input  logic [IDX_W-1:0]  id_wr_idx,
  input  logic              id_mem_rd,
  input  logic              id_mem_wr,
  input  logic              stall,
  input  logic              flush,
  input  logic              mem_wr_en,
  input  logic [IDX_W-1:0]  mem_wr_idx,
  input  logic [DATA_W-1:0] mem_fwd_data,
  input  logic              wb_wr_en,
  input  logic [IDX_W-1:0]  wb_wr_idx,
  input  logic [DATA_W-1:0] wb_fwd_data,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_alu_a,
  output logic [DATA_W-1:0] ex_alu_b,
  output logic [OP_W-1:0]   ex_alu_op,
  output logic [DATA_W-1:0] ex_store_data,
  output logic              ex_wr_en,
  output logic [IDX_W-1:0]  ex_wr_idx,
  output logic              ex_mem_rd,
  output logic              ex_mem_wr,
  output logic              load_use_hazard
);

  localparam int unsigned SHAMT_W = 5;

  // Registered instruction bundle held in the ID/EX stage.
  typedef struct packed {
    logic               valid;
    logic [IDX_W-1:0]   rs_idx;
    logic [IDX_W-1:0]   rt_idx;
    logic [DATA_W-1:0]  rs_data;
    logic [DATA_W-1:0]  rt_data;
    logic [DATA_W-1:0]  imm;
    logic [SHAMT_W-1:0] shamt;
    logic [OP_W-1:0]    alu_op;
    logic               a_sel;
    logic               b_sel;
    logic               wr_en;
    logic [IDX_W-1:0]   wr_idx;
    logic               mem_rd;
    logic               mem_wr;
  } ex_bundle_t;

  ex_bundle_t r_ex;
  ex_bundle_t w_ex_nxt;

  logic w_mem_hit_rs;
  logic w_mem_hit_rt;
  logic w_wb_hit_rs;
  logic w_wb_hit_rt;
  logic [DATA_W-1:0] w_fwd_rs;
  logic [DATA_W-1:0] w_fwd_rt;

  // Forwarding source matches against the registered indices; $0 never matches.
  assign w_mem_hit_rs = mem_wr_en && (mem_wr_idx != '0) && (mem_wr_idx == r_ex.rs_idx);
  assign w_mem_hit_rt = mem_wr_en && (mem_wr_idx != '0) && (mem_wr_idx == r_ex.rt_idx);
  assign w_wb_hit_rs  = wb_wr_en  && (wb_wr_idx  != '0) && (wb_wr_idx  == r_ex.rs_idx);
  assign w_wb_hit_rt  = wb_wr_en  && (wb_wr_idx  != '0) && (wb_wr_idx  == r_ex.rt_idx);

  // Next bundle: flush beats stall beats load.
  always_comb begin
    w_ex_nxt = r_ex;
    if (flush) begin
      w_ex_nxt = '0;
    end else if (stall) begin
      // A value retiring through WB while we hold would otherwise be lost.
      if (w_wb_hit_rs) w_ex_nxt.rs_data = wb_fwd_data;
      if (w_wb_hit_rt) w_ex_nxt.rt_data = wb_fwd_data;
    end else begin
      w_ex_nxt.valid   = id_valid;
      w_ex_nxt.rs_idx  = id_rs_idx;
      w_ex_nxt.rt_idx  = id_rt_idx;
      w_ex_nxt.rs_data = id_rs_data;
      w_ex_nxt.rt_data = id_rt_data;
      w_ex_nxt.imm     = id_imm;
      w_ex_nxt.shamt   = id_shamt;
      w_ex_nxt.a_sel   = id_a_sel;
      w_ex_nxt.b_sel   = id_b_sel;
      w_ex_nxt.wr_idx  = id_wr_idx;
      // Control fields are gated so an invalid ID slot becomes a bubble.
      w_ex_nxt.alu_op  = id_valid ? id_alu_op : '0;
      w_ex_nxt.wr_en   = id_valid & id_wr_en;
      w_ex_nxt.mem_rd  = id_valid & id_mem_rd;
      w_ex_nxt.mem_wr  = id_valid & id_mem_wr;
    end
  end

  // Stage register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex <= '0;
    end else begin
      r_ex <= w_ex_nxt;
    end
  end

  // Operand forwarding, EX/MEM is the younger producer so it wins.
  always_comb begin
    w_fwd_rs = r_ex.rs_data;
    w_fwd_rt = r_ex.rt_data;
    if (w_mem_hit_rs)     w_fwd_rs = mem_fwd_data;
    else if (w_wb_hit_rs) w_fwd_rs = wb_fwd_data;
    if (w_mem_hit_rt)     w_fwd_rt = mem_fwd_data;
    else if (w_wb_hit_rt) w_fwd_rt = wb_fwd_data;
  end

  assign ex_valid      = r_ex.valid;
  assign ex_alu_a      = r_ex.a_sel ? DATA_W'(r_ex.shamt) : w_fwd_rs;
  assign ex_alu_b      = r_ex.b_sel ? r_ex.imm : w_fwd_rt;
  assign ex_alu_op     = r_ex.alu_op;
  assign ex_store_data = w_fwd_rt;
  assign ex_wr_en      = r_ex.wr_en;
  assign ex_wr_idx     = r_ex.wr_idx;
  assign ex_mem_rd     = r_ex.mem_rd;
  assign ex_mem_wr     = r_ex.mem_wr;

  // Conservative: flagged even if the matching source operand is unused.
  assign load_use_hazard = r_ex.valid && r_ex.mem_rd && (r_ex.wr_idx != '0) && id_valid &&
                           ((id_rs_idx == r_ex.wr_idx) || (id_rt_idx == r_ex.wr_idx));

endmodule
